// File: rtl/float32_to_uint_if.sv
// float32_to_uint_if
//   Groups the operand handshake and result/flag signals of float32_to_uint.
//   master: the producer side (drives the operand, observes results).
//   slave : the converter itself.
//   Signals:
//     i_data_in_valid  operand valid, only sampled while o_busy is low
//     i_data_in        binary32 operand {s, e[7:0], f[22:0]}
//     o_busy           converter holds a word
//     o_data_out       unsigned result, held until the next result
//     o_data_out_valid one-cycle pulse marking a new result and flags
//     o_overflow       positive value >= 2^W or +Inf, result saturated
//     o_invalid        NaN, -Inf or negative value with |x| >= 1, result 0
//     o_inexact        nonzero fraction discarded by truncation
interface float32_to_uint_if #(
  parameter int DATA_OUT_WIDTH = 8
);
  logic                      i_data_in_valid;
  logic [31:0]               i_data_in;
  logic                      o_busy;
  logic [DATA_OUT_WIDTH-1:0] o_data_out;
  logic                      o_data_out_valid;
  logic                      o_overflow;
  logic                      o_invalid;
  logic                      o_inexact;

  modport master (
    output i_data_in_valid,
    output i_data_in,
    input  o_busy,
    input  o_data_out,
    input  o_data_out_valid,
    input  o_overflow,
    input  o_invalid,
    input  o_inexact
  );

  modport slave (
    input  i_data_in_valid,
    input  i_data_in,
    output o_busy,
    output o_data_out,
    output o_data_out_valid,
    output o_overflow,
    output o_invalid,
    output o_inexact
  );
endinterface

// File: rtl/float32_to_uint.sv
// float32_to_uint
//   Converts an IEEE-754 binary32 operand to a DATA_OUT_WIDTH-bit unsigned
//   integer, truncating toward zero, saturating on overflow and flagging
//   invalid / overflow / inexact conditions. One word in flight; the
//   significand is aligned one bit position per cycle.
//   Ports:
//     clk      rising-edge clock
//     reset_n  synchronous active-low reset
//     bus      float32_to_uint_if.slave (operand handshake, result, flags)
//
//   state  | meaning
//   IDLE   | waiting for an operand, o_busy low
//   UNPACK | classify operand; specials resolved here, normals load aligner
//   ALIGN  | shift significand left once per cycle until cnt reaches 0
//   PACK   | write result and all flags, raise o_data_out_valid
//   DONE   | drop o_data_out_valid, return to IDLE
module float32_to_uint #(
  parameter int DATA_OUT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  float32_to_uint_if.slave   bus
);

  localparam int W  = DATA_OUT_WIDTH;
  localparam int RW = W + 23;
  localparam logic [8:0] W9 = 9'(W);

  generate
    if (W < 1 || W > 32) begin : g_bad_width
      $error("float32_to_uint: DATA_OUT_WIDTH must be within 1..32");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_PACK,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     opnd_q, opnd_d;
  logic [RW-1:0]   r_q, r_d;
  logic [4:0]      cnt_q, cnt_d;
  // Special-case outcome decided in UNPACK, consumed in PACK.
  logic            spec_q, spec_d;
  logic            sp_ovf_q, sp_ovf_d;
  logic            sp_inv_q, sp_inv_d;
  logic            sp_inx_q, sp_inx_d;
  logic [W-1:0]    data_out_q, data_out_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            inv_q, inv_d;
  logic            inx_q, inx_d;

  logic            op_s;
  logic [7:0]      op_e;
  logic [22:0]     op_f;
  logic [8:0]      k_wide;

  assign op_s   = opnd_q[31];
  assign op_e   = opnd_q[30:23];
  assign op_f   = opnd_q[22:0];
  // Unbiased exponent; only meaningful once e >= 127 has been established.
  assign k_wide = {1'b0, op_e} - 9'd127;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      opnd_q     <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      sp_ovf_q   <= 1'b0;
      sp_inv_q   <= 1'b0;
      sp_inx_q   <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      inv_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opnd_q     <= opnd_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      spec_q     <= spec_d;
      sp_ovf_q   <= sp_ovf_d;
      sp_inv_q   <= sp_inv_d;
      sp_inx_q   <= sp_inx_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      inv_q      <= inv_d;
      inx_q      <= inx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opnd_d     = opnd_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    spec_d     = spec_q;
    sp_ovf_d   = sp_ovf_q;
    sp_inv_d   = sp_inv_q;
    sp_inx_d   = sp_inx_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    inv_d      = inv_q;
    inx_d      = inx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_data_in_valid) begin
          opnd_d  = bus.i_data_in;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        spec_d   = 1'b1;
        sp_ovf_d = 1'b0;
        sp_inv_d = 1'b0;
        sp_inx_d = 1'b0;
        state_d  = S_PACK;
        if (op_e == 8'hFF) begin
          if (op_f != 23'd0) sp_inv_d = 1'b1;
          else if (!op_s)    sp_ovf_d = 1'b1;
          else               sp_inv_d = 1'b1;
        end else if (op_e == 8'd0 && op_f == 23'd0) begin
          // signed zero: plain 0, no flags
        end else if (op_e < 8'd127) begin
          // nonzero magnitude below 1, either sign, denormals included
          sp_inx_d = 1'b1;
        end else if (op_s) begin
          sp_inv_d = 1'b1;
        end else if (k_wide >= W9) begin
          sp_ovf_d = 1'b1;
        end else begin
          spec_d        = 1'b0;
          r_d           = '0;
          r_d[23:0]     = {1'b1, op_f};
          cnt_d         = k_wide[4:0];
          state_d       = S_ALIGN;
        end
      end

      S_ALIGN: begin
        if (cnt_q == 5'd0) begin
          state_d = S_PACK;
        end else begin
          r_d   = r_q << 1;
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_PACK: begin
        if (spec_q) begin
          data_out_d = sp_ovf_q ? '1 : '0;
          inx_d      = sp_inx_q;
        end else begin
          data_out_d = r_q[RW-1:23];
          inx_d      = |r_q[22:0];
        end
        ovf_d   = sp_ovf_q;
        inv_d   = sp_inv_q;
        valid_d = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.o_busy           = (state_q != S_IDLE);
  assign bus.o_data_out       = data_out_q;
  assign bus.o_data_out_valid = valid_q;
  assign bus.o_overflow       = ovf_q;
  assign bus.o_invalid        = inv_q;
  assign bus.o_inexact        = inx_q;

endmodule

// File: tb/tb_float32_to_uint.sv
module tb_float32_to_uint;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  float32_to_uint_if #(.DATA_OUT_WIDTH(8))  bus8 ();
  float32_to_uint_if #(.DATA_OUT_WIDTH(32)) bus32 ();

  float32_to_uint #(.DATA_OUT_WIDTH(8)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus8.slave)
  );

  float32_to_uint #(.DATA_OUT_WIDTH(32)) dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus32.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        inv;
    logic        inx;
    logic [7:0]  lat;
  } exp_t;

  function automatic exp_t mk(input logic [31:0] res, input logic ovf,
                              input logic inv, input logic inx, input int lat);
    exp_t x;
    x.res = res; x.ovf = ovf; x.inv = inv; x.inx = inx; x.lat = 8'(lat);
    return x;
  endfunction

  // Reference: evaluate the real value of the operand and apply the
  // C-style truncating cast rules with saturation.
  function automatic exp_t model(input logic [31:0] x, input int w);
    exp_t  r;
    logic  s;
    int    e;
    int    f;
    real   mag;
    real   fl;
    int    k;
    logic [63:0] maxv;
    s    = x[31];
    e    = int'(x[30:23]);
    f    = int'({9'd0, x[22:0]});
    maxv = (64'd1 << w) - 64'd1;
    r    = mk(32'd0, 1'b0, 1'b0, 1'b0, 2);
    if (e == 255) begin
      if (f != 0)  r.inv = 1'b1;
      else if (!s) begin r.ovf = 1'b1; r.res = maxv[31:0]; end
      else         r.inv = 1'b1;
    end else begin
      if (e == 0) mag = $itor(f) * (2.0 ** (-149.0));
      else        mag = ($itor(f) + 8388608.0) * (2.0 ** $itor(e - 150));
      if (mag == 0.0) begin
      end else if (mag < 1.0) begin
        r.inx = 1'b1;
      end else if (s) begin
        r.inv = 1'b1;
      end else if (mag >= 2.0 ** $itor(w)) begin
        r.ovf = 1'b1;
        r.res = maxv[31:0];
      end else begin
        fl    = $floor(mag);
        r.res = 32'(longint'(fl));
        r.inx = (mag != fl);
        k = 0;
        while (2.0 ** $itor(k + 1) <= mag) k++;
        r.lat = 8'(k + 3);
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [31:0] d);
    if (sel) begin bus32.i_data_in_valid = v; bus32.i_data_in = d; end
    else     begin bus8.i_data_in_valid  = v; bus8.i_data_in  = d; end
  endtask

  task automatic get(input bit sel, output logic [31:0] out, output logic v,
                     output logic ovf, output logic inv, output logic inx,
                     output logic busy);
    if (sel) begin
      out = bus32.o_data_out; v = bus32.o_data_out_valid;
      ovf = bus32.o_overflow; inv = bus32.o_invalid;
      inx = bus32.o_inexact; busy = bus32.o_busy;
    end else begin
      out = {24'd0, bus8.o_data_out}; v = bus8.o_data_out_valid;
      ovf = bus8.o_overflow; inv = bus8.o_invalid;
      inx = bus8.o_inexact; busy = bus8.o_busy;
    end
  endtask

  task automatic convert(input bit sel, input logic [31:0] x, input exp_t e,
                         input string tag);
    logic [31:0] out;
    logic v, ovf, inv, inx, busy;
    int n;
    bit got;
    @(negedge clk);
    drive(sel, 1'b1, x);
    @(posedge clk);
    #1 drive(sel, 1'b0, 32'd0);
    n = 0;
    got = 0;
    while (!got && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      get(sel, out, v, ovf, inv, inx, busy);
      if (v) got = 1;
    end
    chk({tag, ".valid_seen"}, {31'd0, got}, 32'd1);
    chk({tag, ".latency"}, 32'(n), {24'd0, e.lat});
    chk({tag, ".out"}, out, e.res);
    chk({tag, ".flags"}, {29'd0, ovf, inv, inx}, {29'd0, e.ovf, e.inv, e.inx});
    @(posedge clk);
    #1 get(sel, out, v, ovf, inv, inx, busy);
    chk({tag, ".pulse_drop"}, {31'd0, v}, 32'd0);
    chk({tag, ".idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin : main
    logic [31:0] out;
    logic v, ovf, inv, inx, busy;
    logic [31:0] w;
    logic [31:0] last_out;
    int pulses;

    drive(1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    get(1'b0, out, v, ovf, inv, inx, busy);
    chk("reset8.out", out, 32'd0);
    chk("reset8.ctl", {27'd0, busy, v, ovf, inv, inx}, 32'd0);
    get(1'b1, out, v, ovf, inv, inx, busy);
    chk("reset32.out", out, 32'd0);
    chk("reset32.ctl", {27'd0, busy, v, ovf, inv, inx}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    convert(1'b0, 32'h40490FDB, mk(32'd3,   1'b0, 1'b0, 1'b1, 4),  "pi");
    convert(1'b0, 32'h3F800000, mk(32'd1,   1'b0, 1'b0, 1'b0, 3),  "one");
    convert(1'b0, 32'h43800000, mk(32'd255, 1'b1, 1'b0, 1'b0, 2),  "256");
    convert(1'b0, 32'h7F800000, mk(32'd255, 1'b1, 1'b0, 1'b0, 2),  "pinf");
    convert(1'b0, 32'h3F000000, mk(32'd0,   1'b0, 1'b0, 1'b1, 2),  "half");
    convert(1'b0, 32'h80000000, mk(32'd0,   1'b0, 1'b0, 1'b0, 2),  "nzero");
    convert(1'b0, 32'hBF800000, mk(32'd0,   1'b0, 1'b1, 1'b0, 2),  "neg1");
    convert(1'b0, 32'h7FC00000, mk(32'd0,   1'b0, 1'b1, 1'b0, 2),  "nan");
    convert(1'b0, 32'hFF800000, mk(32'd0,   1'b0, 1'b1, 1'b0, 2),  "ninf");
    convert(1'b0, 32'hBF000000, mk(32'd0,   1'b0, 1'b0, 1'b1, 2),  "nhalf");
    convert(1'b0, 32'h00000001, mk(32'd0,   1'b0, 1'b0, 1'b1, 2),  "denorm");
    convert(1'b0, 32'h437F0000, mk(32'd255, 1'b0, 1'b0, 1'b0, 10), "255");
    convert(1'b1, 32'h4F7FFFFF, mk(32'hFFFFFF00, 1'b0, 1'b0, 1'b0, 34), "w32max");

    // A second operand offered while busy must be dropped.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h437F0000);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1 drive(1'b0, 1'b1, 32'h41200000);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 32'd0);
    pulses = 0;
    last_out = 32'd0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 get(1'b0, out, v, ovf, inv, inx, busy);
      if (v) begin pulses++; last_out = out; end
    end
    chk("busy_ignore.pulses", 32'(pulses), 32'd1);
    chk("busy_ignore.out", last_out, 32'd255);

    convert(1'b0, 32'h41200000, mk(32'd10, 1'b0, 1'b0, 1'b0, 6), "ten");
    convert(1'b0, 32'h437F0000, mk(32'd255, 1'b0, 1'b0, 1'b0, 10), "b2b_255");

    // Reset while aligning: outputs cleared, aborted word never reported.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h437F0000);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 get(1'b0, out, v, ovf, inv, inx, busy);
    chk("abort.out", out, 32'd0);
    chk("abort.ctl", {27'd0, busy, v, ovf, inv, inx}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1 get(1'b0, out, v, ovf, inv, inx, busy);
      if (v) pulses++;
    end
    chk("abort.no_pulse", 32'(pulses), 32'd0);

    for (int i = 0; i < 30; i++) begin
      w[31]    = ($urandom_range(0, 3) == 0);
      w[22:0]  = 23'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        w[30:23] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255;
        if ($urandom_range(0, 1) == 0) w[22:0] = 23'd0;
      end else begin
        w[30:23] = 8'($urandom_range(118, 138));
      end
      convert(1'b0, w, model(w, 8), $sformatf("rnd8_%0d", i));
    end
    for (int i = 0; i < 12; i++) begin
      w[31]    = ($urandom_range(0, 4) == 0);
      w[30:23] = 8'($urandom_range(120, 162));
      w[22:0]  = 23'($urandom);
      convert(1'b1, w, model(w, 32), $sformatf("rnd32_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
